// File: rtl/button_bank.sv
`default_nettype none
// ============================================================================
// Module   : button_bank
// Purpose  : N-channel button conditioner: sync, debounce, press/release,
//            long-press and optional auto-repeat (macro BUTTON_BANK_REPEAT_EN).
//            'release' and 'repeat' are reserved words, so those outputs are
//            named release_pulse and repeat_pulse.
// Revision : 1.0 - initial release
// ============================================================================
module button_bank #(
    parameter int N_CH       = 4,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int STABLE_MS  = 10,
    parameter int LONG_MS    = 1000,
    parameter bit ACTIVE_LOW = 1'b0
`ifdef BUTTON_BANK_REPEAT_EN
    ,
    parameter int REPEAT_MS  = 200
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_raw,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_press,
    output logic [N_CH-1:0] repeat_pulse
);

    localparam int c_STABLE_CYC = (CLK_FREQ / 1000) * STABLE_MS;
    localparam int c_LONG_CYC   = (CLK_FREQ / 1000) * LONG_MS;
    localparam int c_DB_W       = $clog2(c_STABLE_CYC) + 1;
    localparam int c_HOLD_W     = $clog2(c_LONG_CYC) + 1;

    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(c_STABLE_CYC - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX  = c_HOLD_W'(c_LONG_CYC);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(c_LONG_CYC - 1);
    localparam logic                c_IDLE      = ACTIVE_LOW;

`ifdef BUTTON_BANK_REPEAT_EN
    localparam int c_REPEAT_CYC = (CLK_FREQ / 1000) * REPEAT_MS;
    localparam int c_REP_W      = $clog2(c_REPEAT_CYC) + 1;
    localparam logic [c_REP_W-1:0] c_REP_LAST = c_REP_W'(c_REPEAT_CYC - 1);
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic                r_sync1_q, r_sync2_q;
        logic                r_level_q, w_level_d;
        logic                r_press_q, w_press_d;
        logic                r_release_q, w_release_d;
        logic                r_long_q, w_long_d;
        logic [c_DB_W-1:0]   r_db_cnt_q, w_db_cnt_d;
        logic [c_HOLD_W-1:0] r_hold_q, w_hold_d;
        logic                w_s, w_held;

        assign w_s = r_sync2_q ^ ACTIVE_LOW;

        always_comb begin
            w_level_d  = r_level_q;
            w_db_cnt_d = '0;
            if (w_s != r_level_q) begin
                if (r_db_cnt_q == c_DB_LAST) begin
                    w_level_d = w_s;
                end else begin
                    w_db_cnt_d = r_db_cnt_q + 1'b1;
                end
            end
            w_press_d   = w_level_d & ~r_level_q;
            w_release_d = ~w_level_d & r_level_q;
            // A hold only advances while the level stays high across the edge
            w_held      = w_level_d & r_level_q;
            w_hold_d    = r_hold_q;
            if (w_press_d) begin
                w_hold_d = '0;
            end else if (w_held && (r_hold_q != c_HOLD_MAX)) begin
                w_hold_d = r_hold_q + 1'b1;
            end
            w_long_d = w_held && (r_hold_q == c_HOLD_LAST);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync1_q   <= c_IDLE;
                r_sync2_q   <= c_IDLE;
                r_level_q   <= 1'b0;
                r_press_q   <= 1'b0;
                r_release_q <= 1'b0;
                r_long_q    <= 1'b0;
                r_db_cnt_q  <= '0;
                r_hold_q    <= '0;
            end else begin
                r_sync1_q   <= btn_raw[i];
                r_sync2_q   <= r_sync1_q;
                r_level_q   <= w_level_d;
                r_press_q   <= w_press_d;
                r_release_q <= w_release_d;
                r_long_q    <= w_long_d;
                r_db_cnt_q  <= w_db_cnt_d;
                r_hold_q    <= w_hold_d;
            end
        end

        assign btn_level[i]     = r_level_q;
        assign press[i]         = r_press_q;
        assign release_pulse[i] = r_release_q;
        assign long_press[i]    = r_long_q;

`ifdef BUTTON_BANK_REPEAT_EN
        logic               r_rep_act_q, w_rep_act_d;
        logic [c_REP_W-1:0] r_rep_cnt_q, w_rep_cnt_d;
        logic               r_rep_q, w_rep_d;

        always_comb begin
            w_rep_act_d = r_rep_act_q;
            w_rep_cnt_d = r_rep_cnt_q;
            w_rep_d     = 1'b0;
            if (!w_held) begin
                w_rep_act_d = 1'b0;
                w_rep_cnt_d = '0;
            end else if (w_long_d) begin
                w_rep_act_d = 1'b1;
                w_rep_cnt_d = '0;
            end else if (r_rep_act_q) begin
                if (r_rep_cnt_q == c_REP_LAST) begin
                    w_rep_d     = 1'b1;
                    w_rep_cnt_d = '0;
                end else begin
                    w_rep_cnt_d = r_rep_cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rep_act_q <= 1'b0;
                r_rep_cnt_q <= '0;
                r_rep_q     <= 1'b0;
            end else begin
                r_rep_act_q <= w_rep_act_d;
                r_rep_cnt_q <= w_rep_cnt_d;
                r_rep_q     <= w_rep_d;
            end
        end

        assign repeat_pulse[i] = r_rep_q;
`else
        assign repeat_pulse[i] = 1'b0;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_button_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_bank
// Purpose  : Scoreboard bench for button_bank (active-high and active-low
//            instances) against a behavioural per-edge reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_bank;

    localparam int N      = 4;
    localparam int STABLE = 4;
    localparam int LONG   = 20;
    localparam int REP    = 8;
`ifdef BUTTON_BANK_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] raw0  = '0;
    logic [N-1:0] raw1  = '1;
    logic [N-1:0] lvl0, prs0, rel0, lng0, rpt0;
    logic [N-1:0] lvl1, prs1, rel1, lng1, rpt1;

    always #5 clk = ~clk;

    button_bank #(
        .N_CH(N), .CLK_FREQ(1000), .STABLE_MS(STABLE), .LONG_MS(LONG), .ACTIVE_LOW(1'b0)
`ifdef BUTTON_BANK_REPEAT_EN
        , .REPEAT_MS(REP)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(raw0), .btn_level(lvl0), .press(prs0),
        .release_pulse(rel0), .long_press(lng0), .repeat_pulse(rpt0)
    );

    button_bank #(
        .N_CH(N), .CLK_FREQ(1000), .STABLE_MS(STABLE), .LONG_MS(LONG), .ACTIVE_LOW(1'b1)
`ifdef BUTTON_BANK_REPEAT_EN
        , .REPEAT_MS(REP)
`endif
    ) dut_al (
        .clk(clk), .rst_n(rst_n), .btn_raw(raw1), .btn_level(lvl1), .press(prs1),
        .release_pulse(rel1), .long_press(lng1), .repeat_pulse(rpt1)
    );

    // Reference model: the pressed value seen by debounce is the raw sample
    // from two edges earlier; events are timed from the edge of the press.
    bit          m_samp  [2][N][2];
    bit          m_level [2][N];
    int          m_run   [2][N];
    int          m_press_k[2][N];
    int          k_edge = 0;
    logic [19:0] m_out   [2];

    logic [39:0] exp_q[$];
    int          vectors     = 0;
    int          miscompares = 0;

    function automatic void model_reset();
        for (int u = 0; u < 2; u++) begin
            for (int ch = 0; ch < N; ch++) begin
                m_samp[u][ch][0] = 1'b0;
                m_samp[u][ch][1] = 1'b0;
                m_level[u][ch]   = 1'b0;
                m_run[u][ch]     = 0;
                m_press_k[u][ch] = -1000000;
            end
            m_out[u] = '0;
        end
    endfunction

    function automatic void model_edge(input logic [N-1:0] r0, input logic [N-1:0] r1);
        k_edge++;
        for (int u = 0; u < 2; u++) begin
            logic [N-1:0] lv, pv, rv, gv, tv;
            for (int ch = 0; ch < N; ch++) begin
                bit p, s, prev;
                int d;
                p    = (u == 0) ? r0[ch] : !r1[ch];
                s    = m_samp[u][ch][1];
                m_samp[u][ch][1] = m_samp[u][ch][0];
                m_samp[u][ch][0] = p;
                prev = m_level[u][ch];
                if (s != prev) begin
                    m_run[u][ch]++;
                    if (m_run[u][ch] == STABLE) begin
                        m_level[u][ch] = s;
                        m_run[u][ch]   = 0;
                    end
                end else begin
                    m_run[u][ch] = 0;
                end
                lv[ch] = m_level[u][ch];
                pv[ch] = m_level[u][ch] && !prev;
                rv[ch] = !m_level[u][ch] && prev;
                gv[ch] = 1'b0;
                tv[ch] = 1'b0;
                if (pv[ch]) m_press_k[u][ch] = k_edge;
                if (m_level[u][ch] && prev) begin
                    d = k_edge - m_press_k[u][ch];
                    gv[ch] = (d == LONG);
                    tv[ch] = REP_EN && (d > LONG) && (((d - LONG) % REP) == 0);
                end
            end
            m_out[u] = {lv, pv, rv, gv, tv};
        end
    endfunction

    // One clock of stimulus: model the edge with the inputs that were held
    // across it, then apply the next inputs and queue the expected outputs.
    task automatic tick(input logic [N-1:0] r0, input logic [N-1:0] r1, input logic rn);
        @(posedge clk);
        if (rst_n) model_edge(raw0, raw1);
        #2;
        raw0  = r0;
        raw1  = r1;
        rst_n = rn;
        if (!rn) model_reset();
        exp_q.push_back({m_out[0], m_out[1]});
    endtask

    task automatic hold(input logic [N-1:0] r0, input logic [N-1:0] r1, input int n);
        for (int c = 0; c < n; c++) tick(r0, r1, 1'b1);
    endtask

    initial begin : monitor
        logic [39:0] exp_v, act_v;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act_v = {lvl0, prs0, rel0, lng0, rpt0, lvl1, prs1, rel1, lng1, rpt1};
                vectors++;
                if (act_v !== exp_v) begin
                    miscompares++;
                    $display("FAIL outputs @%0t {lvl,prs,rel,lng,rpt}x2: got %h expected %h",
                             $time, act_v, exp_v);
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: time limit reached, %0d vectors, %0d miscompares",
                 vectors, miscompares);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int          cnt0[N];
        int          cnt1[N];
        logic [N-1:0] r0, r1;
        logic         rn;

        model_reset();
        for (int c = 0; c < 3; c++) tick('0, '1, 1'b0);
        hold('0, '1, 4);

        // Clean press and release on ch0
        hold(4'b0001, '1, 30);
        hold('0, '1, 10);

        // Bounce on ch1 with 3-cycle pulses, then held
        hold(4'b0010, '1, 3);
        hold('0, '1, 3);
        hold(4'b0010, '1, 3);
        hold('0, '1, 3);
        hold(4'b0010, '1, 20);
        hold('0, '1, 10);

        // Long hold on ch2
        hold(4'b0100, '1, 56);
        hold('0, '1, 10);

        // Short hold on ch3
        hold(4'b1000, '1, 16);
        hold('0, '1, 12);

        // Active-low instance: drive its ch0 low
        hold('0, 4'b1110, 12);
        hold('0, '1, 10);

        // Simultaneous presses, reset mid-hold with buttons still down
        hold('1, '0, 15);
        for (int c = 0; c < 3; c++) tick('1, '0, 1'b0);
        hold('1, '0, 15);
        hold('0, '1, 10);

        // Randomised bouncing, long holds and occasional resets
        r0 = '0;
        r1 = '1;
        for (int ch = 0; ch < N; ch++) begin
            cnt0[ch] = $urandom_range(1, 30);
            cnt1[ch] = $urandom_range(1, 30);
        end
        for (int c = 0; c < 3000; c++) begin
            for (int ch = 0; ch < N; ch++) begin
                if (cnt0[ch] == 0) begin
                    r0[ch]   = ~r0[ch];
                    cnt0[ch] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4)
                                                           : $urandom_range(5, 60);
                end else begin
                    cnt0[ch]--;
                end
                if (cnt1[ch] == 0) begin
                    r1[ch]   = ~r1[ch];
                    cnt1[ch] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4)
                                                           : $urandom_range(5, 60);
                end else begin
                    cnt1[ch]--;
                end
            end
            rn = ($urandom_range(0, 399) != 0);
            tick(r0, r1, rn);
        end

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_bank.md
BUTTON_BANK -- requirements
Module: button_bank

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent button channels (1..32).
REQ-002 SHALL have parameter CLK_FREQ, default 50_000_000: clock frequency in Hz.
REQ-003 SHALL have parameter STABLE_MS, default 10: debounce time; STABLE_CYC = (CLK_FREQ/1000)*STABLE_MS, which SHALL be at least 1.
REQ-004 SHALL have parameter LONG_MS, default 1000: hold time for a long press; LONG_CYC = (CLK_FREQ/1000)*LONG_MS, which SHALL be greater than 0.
REQ-005 SHALL have parameter ACTIVE_LOW, default 0: when 1, a raw low level means pressed.
REQ-006 SHALL have port clk, input, 1 bit: system clock; all logic on the rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port btn_raw, input, N_CH bits: asynchronous raw pin levels.
REQ-009 SHALL have port btn_level, output, N_CH bits: registered debounced level, 1 = pressed.
REQ-010 SHALL have port press, output, N_CH bits: one-cycle pulse on each accepted 0->1 transition of btn_level.
REQ-011 SHALL have port release, output, N_CH bits: one-cycle pulse on each accepted 1->0 transition of btn_level.
REQ-012 SHALL have port long_press, output, N_CH bits: one-cycle pulse once per hold reaching LONG_CYC.
REQ-013 SHALL have port repeat, output, N_CH bits: auto-repeat pulses (see Configuration).

Function
REQ-014 Each channel SHALL be fully independent, with its own synchroniser, counters and outputs; simultaneous events on different channels SHALL NOT interact.
REQ-015 Each btn_raw bit SHALL pass through a 2-flop synchroniser; when ACTIVE_LOW=1 the bit SHALL be inverted after synchronisation, giving s.
REQ-016 Debounce counter SHALL increment on every cycle where s != btn_level, and SHALL clear to 0 on any cycle where s == btn_level.
REQ-017 On the edge where the counter completes STABLE_CYC consecutive mismatch cycles, btn_level SHALL take the value of s and the counter SHALL clear.
REQ-018 Latency from a clean raw edge to the btn_level change SHALL be exactly 2 + STABLE_CYC cycles.
REQ-019 press and release SHALL be asserted in the same cycle btn_level first shows its new value, for exactly one cycle.
REQ-020 A glitch shorter than STABLE_CYC synchronised cycles SHALL produce no change on btn_level and no pulses.
REQ-021 Hold counter:
  - SHALL clear to 0 in the cycle press is asserted;
  - SHALL increment each cycle while btn_level=1;
  - SHALL saturate and never wrap.
REQ-022 long_press SHALL pulse for one cycle when the hold counter equals LONG_CYC, at most once per hold.
REQ-023 A release before LONG_CYC SHALL suppress long_press for that hold.
REQ-024 Counter widths SHALL be $clog2 of the respective maximum plus 1.

Reset
REQ-025 While rst_n=0, SHALL clear btn_level, press, release, long_press, repeat, and all counters to 0.
REQ-026 While rst_n=0, SHALL load the synchroniser flops with the raw inactive level (ACTIVE_LOW), so no spurious press occurs after reset.
REQ-027 Reset asserted mid-debounce or mid-hold SHALL abort it; after reset a held button SHALL produce a fresh press after 2 + STABLE_CYC cycles.

Configuration
REQ-028 With macro BUTTON_BANK_REPEAT_EN defined, SHALL add parameter REPEAT_MS, default 200, with REPEAT_CYC = (CLK_FREQ/1000)*REPEAT_MS, at least 1.
REQ-029 With BUTTON_BANK_REPEAT_EN defined, repeat SHALL pulse REPEAT_CYC cycles after long_press, and every REPEAT_CYC cycles thereafter while btn_level=1; pulses SHALL stop on release.
REQ-030 Without BUTTON_BANK_REPEAT_EN, repeat SHALL be constant 0 and no repeat logic SHALL be synthesised.

Verification
REQ-031 All scenarios SHALL use CLK_FREQ=1000, STABLE_MS=4, LONG_MS=20, REPEAT_MS=8, N_CH=4.
REQ-032 Clean press: ch0 raw 0->1 held -> btn_level[0]=1 and press[0]=1 exactly 6 cycles after the edge, 1 cycle wide.
REQ-033 Bounce: ch1 toggles with 3-cycle pulses for 12 cycles, then held high -> a single press[1] 6 cycles after the final edge; no release.
REQ-034 Long press and repeat: ch2 held 50 cycles -> long_press[2] 20 cycles after press[2]; with BUTTON_BANK_REPEAT_EN, repeat[2] at +8 and +16 after long_press; without the macro, repeat stays 0.
REQ-035 Short hold: ch3 held 10 cycles after press -> release[3] pulse, and no long_press[3].
REQ-036 ACTIVE_LOW=1 with all raw=1 through reset -> all outputs 0; driving raw[0]=0 -> press[0] after 6 cycles.
REQ-037 Simultaneous presses on all 4 channels, with rst_n pulsed low mid-hold -> all outputs clear immediately; 4 fresh press pulses 6 cycles after reset release.
